mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the data-memory port driven by the execute stage.
- Decodes the ALU-computed byte address, store byte-enables and a load strobe.
- Returns registered read data with the same 1-cycle latency as DMEM, so the writeback mux can treat both alike.
- Holds cycle/instruction counters, an LED register and a TX byte FIFO that feeds a downstream UART transmitter over a valid/ready handshake.

---
 rtl/mmio_responder.sv | 85 ++++++++
 tb/tb_mmio_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O block with counters, LED register and TX byte FIFO
module mmio_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter logic [3:0] IO_TAG = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] led_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [5:0] OFF_STATUS = 6'h00;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_CYCLE  = 6'h04;
  localparam logic [5:0] OFF_INSTR  = 6'h05;
  localparam logic [5:0] OFF_CTRCLR = 6'h06;
  localparam logic [5:0] OFF_LED    = 6'h08;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d, led_q, led_d, rdata_q, rdata_d, rd_val;
  logic        ovf_q, ovf_d;
  logic        sel, wr, empty, full, push_req, push, pop, ctrclr;
  logic [5:0]  off;
  logic        unused_addr;
  assign unused_addr = ^{addr[27:8], addr[1:0]};
  assign sel      = addr[31:28] == IO_TAG;
  assign off      = addr[7:2];
  assign wr       = sel && |wea;
  assign empty    = wp_q == rp_q;
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push_req = sel && wea[0] && off == OFF_TXDATA;
  // Fullness is judged before this cycle's pop, so a pop never rescues a push
  assign push     = push_req && !full;
  assign pop      = !empty && tx_ready;
  assign ctrclr   = wr && off == OFF_CTRCLR;
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];
  assign rdata    = rdata_q;
  assign led_out  = led_q;
  always_comb begin
    rd_val = off == OFF_STATUS ? {29'd0, ovf_q, empty, !full} :
             off == OFF_CYCLE  ? cyc_q :
             off == OFF_INSTR  ? ins_q :
             off == OFF_LED    ? led_q : 32'd0;
    rdata_d = (re && sel) ? rd_val : 32'd0;
    wp_d    = wp_q + {{AW{1'b0}}, push};
    rp_d    = rp_q + {{AW{1'b0}}, pop};
    ovf_d   = (push_req && full) ? 1'b1 : (wr && off == OFF_STATUS) ? 1'b0 : ovf_q;
    cyc_d   = ctrclr ? 32'd0 : cyc_q + 32'd1;
    ins_d   = ctrclr ? 32'd0 : ins_q + {31'd0, inst_retire};
    led_d   = led_q;
    for (int i = 0; i < 4; i++)
      if (wr && off == OFF_LED && wea[i]) led_d[8*i +: 8] = wdata[8*i +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= 32'd0;
      ins_q   <= 32'd0;
      led_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      led_q   <= led_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= wdata[7:0];
  end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: scoreboard bench for mmio_responder against a queue-based reference model
module tb_mmio_responder;
  localparam int D = 8;
  logic clk = 0, rst = 1;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0]  wea = 0;
  logic re = 0, inst_retire = 0, tx_ready = 0;
  logic [31:0] rdata, led_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  mmio_responder #(.FIFO_DEPTH(D), .IO_TAG(4'h8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wea(wea), .re(re),
    .inst_retire(inst_retire), .rdata(rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .led_out(led_out)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [31:0] rq[$];
  logic [7:0]  txq[$];
  int occ_m;
  bit ovf_m, pend, rdy_g, ir_g;
  logic [31:0] cyc_m, ins_m, led_m;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] model_rd(input logic [5:0] off);
    case (off)
      6'h00:   return {29'd0, ovf_m, occ_m == 0, occ_m < D};
      6'h04:   return cyc_m;
      6'h05:   return ins_m;
      6'h08:   return led_m;
      default: return 32'd0;
    endcase
  endfunction
  // One bus cycle: drive inputs, record expectations, advance the model across the next edge
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input bit r);
    bit s, wr, pushr, popm, full;
    logic [5:0] off;
    addr = a; wdata = d; wea = w; re = r; inst_retire = ir_g; tx_ready = rdy_g;
    s = a[31:28] == 4'h8;
    off = a[7:2];
    wr = s && w != 0;
    if (r && s) rq.push_back(model_rd(off));
    pushr = wr && w[0] && off == 6'h02;
    popm = occ_m > 0 && rdy_g;
    full = occ_m == D;
    if (pushr && full) ovf_m = 1;
    else if (wr && off == 6'h00) ovf_m = 0;
    occ_m = occ_m - int'(popm) + int'(pushr && !full);
    if (pushr && !full) txq.push_back(d[7:0]);
    cyc_m = (wr && off == 6'h06) ? 32'd0 : cyc_m + 32'd1;
    ins_m = (wr && off == 6'h06) ? 32'd0 : ins_m + 32'(ir_g);
    if (wr && off == 6'h08)
      for (int i = 0; i < 4; i++) if (w[i]) led_m[8*i +: 8] = d[8*i +: 8];
    @(posedge clk); #2;
  endtask
  task automatic rd(input logic [31:0] a); cyc(a, 32'd0, 4'd0, 1'b1); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w); cyc(a, d, w, 1'b0); endtask
  task automatic idle(); cyc(32'd0, 32'd0, 4'd0, 1'b0); endtask
  task automatic do_reset();
    rst = 1; addr = 0; wdata = 0; wea = 0; re = 0; inst_retire = 0; tx_ready = 0;
    rdy_g = 0; ir_g = 0;
    rq.delete(); txq.delete();
    occ_m = 0; ovf_m = 0; cyc_m = 0; ins_m = 0; led_m = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
  endtask
  always @(negedge clk) begin
    if (rst) pend = 0;
    else begin
      if (pend) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata: read response with no expectation queued");
        end else chk("rdata", rdata, rq.pop_front());
      end else chk("rdata_idle", rdata, 32'd0);
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_data: handshake with nothing expected, got %h", tx_data);
        end else chk("tx_data", {24'd0, tx_data}, {24'd0, txq.pop_front()});
      end
      pend = re && addr[31:28] == 4'h8;
    end
  end
  initial begin
    logic [5:0] offs [7];
    offs = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h08, 6'h0C};
    do_reset();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_led", led_out, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rd(32'h8000_0000);
    for (int i = 0; i < 10; i++) begin ir_g = (i % 3 == 0); idle(); end
    ir_g = 0;
    rd(32'h8000_0010);
    rd(32'h8000_0014);
    wr(32'h8000_0018, 32'd0, 4'hF);
    idle();
    rd(32'h8000_0010);
    rd(32'h8000_0014);
    wr(32'h8000_0020, 32'hAABB_CCDD, 4'hF);
    wr(32'h8000_0020, 32'h0000_1100, 4'b0010);
    chk("led_bytes", led_out, 32'hAABB_11DD);
    rd(32'h8000_0020);
    rd(32'h4000_0010);
    rd(32'h8000_0030);
    wr(32'h4000_0020, 32'h1234_5678, 4'hF);
    chk("led_wrong_tag", led_out, 32'hAABB_11DD);
    rdy_g = 0;
    for (int i = 0; i < 8; i++) wr(32'h8000_0008, 32'h41 + i, 4'h1);
    rd(32'h8000_0000);
    wr(32'h8000_0008, 32'h49, 4'h1);
    rd(32'h8000_0000);
    rdy_g = 1;
    repeat (10) idle();
    chk("drained_tx_valid", {31'd0, tx_valid}, 32'd0);
    wr(32'h8000_0000, 32'd0, 4'hF);
    rd(32'h8000_0000);
    rdy_g = 0;
    for (int i = 0; i < 3; i++) wr(32'h8000_0008, 32'h10 + i, 4'h1);
    rdy_g = 1;
    for (int i = 0; i < 5; i++) wr(32'h8000_0008, 32'h20 + i, 4'h1);
    chk("pushpop_tx_valid", {31'd0, tx_valid}, 32'd1);
    rdy_g = 0;
    rd(32'h8000_0000);
    rdy_g = 1;
    repeat (5) idle();
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      rdy_g = ($urandom_range(0, 2) != 0);
      ir_g = $urandom_range(0, 1);
      a = {($urandom_range(0, 7) == 0) ? 4'h4 : 4'h8, 20'($urandom), offs[$urandom_range(0, 6)], 2'($urandom)};
      case (op)
        0, 1, 2: rd(a);
        3: wr({4'h8, 20'd0, 6'h08, 2'b00}, $urandom, 4'($urandom));
        4, 5, 6: wr({a[31:28], 20'd0, 6'h02, 2'b00}, $urandom, 4'($urandom) | 4'h1);
        7: wr({4'h8, 20'd0, 6'h00, 2'b00}, $urandom, 4'($urandom_range(1, 15)));
        8: if ($urandom_range(0, 4) == 0) wr(a, $urandom, 4'hF); else idle();
        default: idle();
      endcase
    end
    ir_g = 0;
    rd(32'h8000_0000);
    rdy_g = 1;
    repeat (12) idle();
    chk("final_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("led_final", led_out, led_m);
    rdy_g = 0;
    wr(32'h8000_0008, 32'h5A, 4'h1);
    wr(32'h8000_0008, 32'h5B, 4'h1);
    do_reset();
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    rd(32'h8000_0000);
    idle();
    idle();
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("txq_drained", 32'(txq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
